pad_filter: RTL and testbench

- Inverse of the crop stage: accepts a cropped OUT_ROWS x OUT_COLS pixel stream and re-embeds it into a full IN_ROWS x IN_COLS frame.
- The window's top-left corner sits at (Y_1, X_1); every pixel outside the window is PAD_VALUE.
- Sits downstream of processing done on the cropped region and restores full-frame geometry for display or readback.
- Valid/ready handshake on both sides, with a registered output stage.

---
 rtl/pad_filter_pkg.sv | 25 ++
 rtl/pad_filter_raster_counter.sv | 49 ++++
 rtl/pad_filter.sv | 114 +++++++++++
 tb/tb_pad_filter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pad_filter_pkg.sv
// Shared geometry defaults and the window test used by both the crop and pad stages,
// so both ends of the crop/pad pair agree on where the window sits.
package pad_filter_pkg;

  localparam int DEF_PIXEL_BIT_WIDTH = 12;
  localparam int DEF_IN_ROWS         = 40;
  localparam int DEF_IN_COLS         = 40;
  localparam int DEF_OUT_ROWS        = 20;
  localparam int DEF_OUT_COLS        = 20;
  localparam int DEF_Y_1             = 10;
  localparam int DEF_X_1             = 10;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // True when full-frame position (x, y) falls inside the cropped window.
  function automatic logic in_win(input int x, input int y,
                                  input int y1, input int x1,
                                  input int rows, input int cols);
    return (y >= y1) && (y < y1 + rows) && (x >= x1) && (x < x1 + cols);
  endfunction

endpackage

// File: rtl/pad_filter_raster_counter.sv
// Raster-order x/y position counter: advances on en_i, wraps at the frame end,
// and flags the last pixel of the frame.
module raster_counter #(
  parameter int COLS = 40,
  parameter int ROWS = 40,
  parameter int XW   = $clog2(COLS + 1),
  parameter int YW   = $clog2(ROWS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          eol;

  assign eol    = (x_q == XW'(COLS - 1));
  assign last_o = eol && (y_q == YW'(ROWS - 1));
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      if (eol) begin
        x_d = '0;
        y_d = last_o ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/pad_filter.sv
// Re-embeds a cropped pixel stream into a full frame, filling everything outside
// the window with PAD_VALUE; registered output with valid/ready on both sides.
module pad_filter
  import pad_filter_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
  parameter int IN_ROWS         = DEF_IN_ROWS,
  parameter int IN_COLS         = DEF_IN_COLS,
  parameter int OUT_ROWS        = DEF_OUT_ROWS,
  parameter int OUT_COLS        = DEF_OUT_COLS,
  parameter int Y_1             = DEF_Y_1,
  parameter int X_1             = DEF_X_1,
  parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eol
);

  localparam int XW = $clog2(IN_COLS + 1);
  localparam int YW = $clog2(IN_ROWS + 1);

  if ((Y_1 + OUT_ROWS > IN_ROWS) || (X_1 + OUT_COLS > IN_COLS)) begin : g_geom_err
    $error("pad_filter: crop window does not fit inside the full frame");
  end

  state_e                     state_q, state_d;
  logic                       vld_q, vld_d;
  logic [PIXEL_BIT_WIDTH-1:0] pix_q, pix_d;
  logic                       sof_q, sof_d;
  logic                       eol_q, eol_d;
  logic                       cnt_en, last_pix, load_en, win;
  logic [XW-1:0]              x;
  logic [YW-1:0]              y;

  raster_counter #(
    .COLS (IN_COLS),
    .ROWS (IN_ROWS),
    .XW   (XW),
    .YW   (YW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (cnt_en),
    .x_o    (x),
    .y_o    (y),
    .last_o (last_pix)
  );

  assign load_en = !vld_q || out_ready;
  assign win     = in_win(int'(x), int'(y), Y_1, X_1, OUT_ROWS, OUT_COLS);
  // in_ready never looks at in_valid; the only out_ready dependency is via load_en.
  assign in_ready = (state_q == ST_EMIT) && load_en && win;

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    pix_d   = pix_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    cnt_en  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (out_ready) vld_d = 1'b0;
        if (in_valid)  state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (load_en) begin
          if (!win || in_valid) begin
            vld_d  = 1'b1;
            pix_d  = win ? pixel_in : PAD_VALUE;
            sof_d  = (x == '0) && (y == '0);
            eol_d  = (x == XW'(IN_COLS - 1));
            cnt_en = 1'b1;
            if (last_pix) state_d = ST_WAIT;
          end else begin
            // Window pixel not yet available: bubble, position holds.
            vld_d = 1'b0;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WAIT;
      vld_q   <= 1'b0;
      pix_q   <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      pix_q   <= pix_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  end

  assign pixel_out = pix_q;
  assign out_valid = vld_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;

endmodule

// File: tb/tb_pad_filter.sv
// Scoreboard bench for pad_filter on a 6x6 frame with a 2x2 window at (row 2, col 3).
module tb_pad_filter;

  localparam int PW = 12;
  localparam int IR = 6, IC = 6, OR = 2, OC = 2, Y1 = 2, X1 = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] pixel_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sof;
  logic          out_eol;

  pad_filter #(
    .PIXEL_BIT_WIDTH (PW),
    .IN_ROWS         (IR),
    .IN_COLS         (IC),
    .OUT_ROWS        (OR),
    .OUT_COLS        (OC),
    .Y_1             (Y1),
    .X_1             (X1),
    .PAD_VALUE       ('0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pixel_in  (pixel_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixel_out (pixel_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pix;
    logic          sof;
    logic          eol;
  } exp_t;

  exp_t          expq[$];
  logic [PW-1:0] inq[$];
  int            n_tests = 0, n_fail = 0, n_out = 0, cyc = 0;
  int            last_pop_cyc = 0, last_gap = -1;
  bit            have_prev = 0, hold_in = 0, toggle = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Queue one frame's four window pixels and the 36 full-frame outputs they imply.
  task automatic push_frame(input logic [PW-1:0] a, input logic [PW-1:0] b,
                            input logic [PW-1:0] c, input logic [PW-1:0] d);
    logic [PW-1:0] w[4];
    exp_t e;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int i = 0; i < IR * IC; i++) begin
      int r, cc;
      r  = i / IC;
      cc = i % IC;
      e.pix = (r >= Y1 && r < Y1 + OR && cc >= X1 && cc < X1 + OC) ?
              w[(r - Y1) * OC + (cc - X1)] : '0;
      e.sof = (i == 0);
      e.eol = (cc == IC - 1);
      expq.push_back(e);
    end
    for (int i = 0; i < 4; i++) inq.push_back(w[i]);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (expq.size() > 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk({name, " outputs left at timeout"}, expq.size(), 0);
  endtask

  // Input driver: holds pixel/valid stable through the edge, pops on handshake.
  always begin : driver
    bit fire;
    @(negedge clk);
    fire = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (fire && inq.size() > 0) void'(inq.pop_front());
    in_valid  = (inq.size() > 0) && !hold_in && reset;
    pixel_in  = (inq.size() > 0) ? inq[0] : '0;
    out_ready = toggle ? !out_ready : 1'b1;
  end

  // Monitor: checks each accepted output against the scoreboard and stall stability.
  always @(negedge clk) begin : monitor
    static bit        stall = 0;
    static logic [14:0] saved = '0;
    cyc++;
    if (!reset) begin
      stall = 0;
    end else begin
      if (stall)
        chk($sformatf("hold stable at out %0d", n_out),
            int'({pixel_out, out_sof, out_eol, out_valid}), int'(saved));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected output", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk($sformatf("out %0d pixel", n_out), int'(pixel_out), int'(e.pix));
          chk($sformatf("out %0d sof", n_out), int'(out_sof), int'(e.sof));
          chk($sformatf("out %0d eol", n_out), int'(out_eol), int'(e.eol));
          if (e.sof && have_prev) last_gap = cyc - last_pop_cyc - 1;
        end
        last_pop_cyc = cyc;
        have_prev    = 1;
        n_out++;
      end
      stall = out_valid && !out_ready;
      saved = {pixel_out, out_sof, out_eol, out_valid};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, k;
    #12;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset pixel_out", int'(pixel_out), 0);
    chk("reset out_sof", int'(out_sof), 0);
    chk("reset out_eol", int'(out_eol), 0);
    chk("reset in_ready", int'(in_ready), 0);
    @(negedge clk);
    reset = 1'b1;

    // Test 6: idle after reset, no padding frames.
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("t6 idle out_valid", int'(out_valid), 0);
      chk("t6 idle in_ready", int'(in_ready), 0);
    end

    // Test 1: one frame, out_ready held high.
    b = n_out;
    push_frame(1, 2, 3, 4);
    wait_done("t1");
    chk("t1 output count", n_out - b, 36);
    repeat (5) @(posedge clk);
    #2;
    chk("t1 no trailing padding", n_out - b, 36);
    chk("t1 idle out_valid", int'(out_valid), 0);

    // Test 2: out_ready toggling every cycle.
    b = n_out;
    toggle = 1;
    push_frame(5, 6, 7, 8);
    wait_done("t2");
    toggle = 0;
    chk("t2 output count", n_out - b, 36);
    repeat (3) @(posedge clk);

    // Test 3: input starved when position 15 is reached.
    b = n_out;
    push_frame(1, 2, 3, 4);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 100);
    hold_in = 1;
    repeat (25) @(posedge clk);
    #2;
    chk("t3 outputs before bubble", n_out - b, 15);
    chk("t3 bubble out_valid", int'(out_valid), 0);
    hold_in = 0;
    wait_done("t3");
    chk("t3 output count", n_out - b, 36);
    repeat (3) @(posedge clk);

    // Test 4: two frames back to back.
    b = n_out;
    last_gap = -1;
    push_frame(1, 2, 3, 4);
    push_frame(11, 12, 13, 14);
    wait_done("t4");
    chk("t4 output count", n_out - b, 72);
    chk("t4 idle cycles between frames", last_gap, 1);
    repeat (3) @(posedge clk);

    // Test 5: asynchronous reset mid-frame.
    b = n_out;
    push_frame(21, 22, 23, 24);
    k = 0;
    while (n_out - b < 20 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("t5 reached output 20", int'(n_out - b >= 20), 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t5 async out_valid", int'(out_valid), 0);
    chk("t5 async pixel_out", int'(pixel_out), 0);
    chk("t5 async in_ready", int'(in_ready), 0);
    expq.delete();
    inq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    b = n_out;
    push_frame(31, 32, 33, 34);
    wait_done("t5");
    chk("t5 output count after reset", n_out - b, 36);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
